// File: rtl/calc_pkg.sv
// calc_unit shared definitions: opcodes, FSM states,
// iterative-datapath modes and flag bit positions.
package calc_pkg;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_XOR  = 4'h4;
   localparam logic [3:0] OP_CMP  = 4'h5;
   localparam logic [3:0] OP_MOV  = 4'h6;
   localparam logic [3:0] OP_MUL  = 4'h7;
   localparam logic [3:0] OP_SLL  = 4'h8;
   localparam logic [3:0] OP_SLR  = 4'h9;
   localparam logic [3:0] OP_SRL  = 4'hA;
   localparam logic [3:0] OP_SRA  = 4'hB;
   localparam logic [3:0] OP_DIVU = 4'hC;
   localparam logic [3:0] OP_REMU = 4'hD;

   localparam int FLG_S = 3;
   localparam int FLG_Z = 2;
   localparam int FLG_C = 1;
   localparam int FLG_V = 0;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   typedef enum logic [1:0] {
      IT_MUL,
      IT_DIV,
      IT_REM
   } iter_mode_t;

endpackage

// File: rtl/calc_iter.sv
// Bit-serial shift-add multiplier / restoring divider.
// The start edge performs the first of WIDTH iterations.
module calc_iter
   import calc_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  iter_mode_t       mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             hi_nonzero
);

   localparam logic [SHW:0] LAST = (SHW+1)'(WIDTH);

   logic [WIDTH-1:0] hi, lo, dv;
   logic [WIDTH-1:0] s_hi, s_lo, s_dv;
   logic [WIDTH-1:0] n_hi, n_lo;
   iter_mode_t       md, s_md;
   logic             run;
   logic [SHW:0]     cnt;
   logic [WIDTH:0]   sum, shl, dif;

   // on start, iterate straight from the operands
   always_comb begin
      s_hi = start ? '0 : hi;
      s_lo = start ? b : lo;
      s_dv = start ? a : dv;
      s_md = start ? mode : md;
      sum  = {1'b0, s_hi} + (s_lo[0] ? {1'b0, s_dv} : '0);
      shl  = {s_hi, s_lo[WIDTH-1]};
      dif  = shl - {1'b0, s_dv};
      n_hi = s_hi;
      n_lo = s_lo;
      if (s_md == IT_MUL) begin
         {n_hi, n_lo} = {sum, s_lo[WIDTH-1:1]};
      end else if (dif[WIDTH]) begin
         n_hi = shl[WIDTH-1:0];
         n_lo = {s_lo[WIDTH-2:0], 1'b0};
      end else begin
         n_hi = dif[WIDTH-1:0];
         n_lo = {s_lo[WIDTH-2:0], 1'b1};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi  <= '0;
         lo  <= '0;
         dv  <= '0;
         md  <= IT_MUL;
         run <= 1'b0;
         cnt <= '0;
      end else if (start || run) begin
         hi  <= n_hi;
         lo  <= n_lo;
         dv  <= s_dv;
         md  <= s_md;
         cnt <= start ? (SHW+1)'(1) : cnt + 1'b1;
         run <= start ? 1'b1 : (cnt != LAST - 1'b1);
      end
   end

   assign done       = (cnt == LAST);
   assign result     = (md == IT_REM) ? hi : lo;
   assign hi_nonzero = |hi;

endmodule

// File: rtl/calc_unit.sv
// Handshaked ALU: single-cycle ops plus iterative
// MUL/DIVU/REMU, one result held until consumed.
module calc_unit
   import calc_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [SHW-1:0]   shamt,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);

   state_t             state, nxt;
   iter_mode_t         mode;
   logic [3:0]         op_r;
   logic               start, ld_sc, ld_it;
   logic               is_it, zdiv, legal, c, v;
   logic               it_done, it_hnz, it_ovf;
   logic [WIDTH-1:0]   sc_res, it_res;
   logic [3:0]         sc_flg, it_flg;
   logic [WIDTH:0]     wide;
   logic [2*WIDTH-1:0] rot;

   calc_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_iter (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .mode       (mode),
      .a          (a),
      .b          (b),
      .done       (it_done),
      .result     (it_res),
      .hi_nonzero (it_hnz)
   );

   always_comb begin
      sc_res = '0;
      wide   = '0;
      rot    = '0;
      c      = 1'b0;
      v      = 1'b0;
      legal  = 1'b1;
      unique case (op)
         OP_ADD: begin
            wide = {1'b0, a} + {1'b0, b};
            {c, sc_res} = wide;
            v = (a[WIDTH-1] == b[WIDTH-1])
              && (sc_res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB, OP_CMP: begin
            wide = {1'b0, b} - {1'b0, a};
            {c, sc_res} = wide;
            v = (a[WIDTH-1] != b[WIDTH-1])
              && (sc_res[WIDTH-1] != b[WIDTH-1]);
         end
         OP_AND: sc_res = a & b;
         OP_OR:  sc_res = a | b;
         OP_XOR: sc_res = a ^ b;
         OP_MOV: sc_res = b;
         OP_SLL: begin
            wide = {1'b0, b} << shamt;
            {c, sc_res} = wide;
         end
         OP_SLR: begin
            rot = {b, b} << shamt;
            sc_res = rot[2*WIDTH-1:WIDTH];
         end
         OP_SRL: begin
            wide = {b, 1'b0} >> shamt;
            {sc_res, c} = wide;
         end
         OP_SRA: begin
            wide = $signed({b, 1'b0}) >>> shamt;
            {sc_res, c} = wide;
         end
         // only reach the output on divide-by-zero
         OP_DIVU: begin
            sc_res = '1;
            v = 1'b1;
         end
         OP_REMU: begin
            sc_res = b;
            v = 1'b1;
         end
         OP_MUL: sc_res = '0;
         default: legal = 1'b0;
      endcase
      sc_flg = '0;
      if (legal) begin
         sc_flg[FLG_S] = sc_res[WIDTH-1];
         sc_flg[FLG_Z] = (sc_res == '0);
         sc_flg[FLG_C] = c;
         sc_flg[FLG_V] = v;
      end
   end

   always_comb begin
      is_it  = (op == OP_MUL) || (op == OP_DIVU)
            || (op == OP_REMU);
      zdiv   = ((op == OP_DIVU) || (op == OP_REMU))
            && (a == '0);
      mode   = (op == OP_MUL)  ? IT_MUL :
               (op == OP_DIVU) ? IT_DIV : IT_REM;
      it_ovf = (op_r == OP_MUL) && it_hnz;
      it_flg = '0;
      it_flg[FLG_S] = it_res[WIDTH-1];
      it_flg[FLG_Z] = (it_res == '0);
      it_flg[FLG_C] = it_ovf;
      it_flg[FLG_V] = it_ovf;
   end

   always_comb begin
      nxt      = state;
      in_ready = 1'b0;
      start    = 1'b0;
      ld_sc    = 1'b0;
      ld_it    = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (is_it && !zdiv) begin
                  start = 1'b1;
                  nxt   = BUSY;
               end else begin
                  ld_sc = 1'b1;
                  nxt   = DONE;
               end
            end
         end
         BUSY: begin
            if (it_done) begin
               ld_it = 1'b1;
               nxt   = DONE;
            end
         end
         DONE: begin
            if (out_ready) nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_r   <= '0;
         result <= '0;
         flags  <= '0;
      end else begin
         if (start) op_r <= op;
         if (ld_sc) begin
            result <= sc_res;
            flags  <= sc_flg;
         end else if (ld_it) begin
            result <= it_res;
            flags  <= it_flg;
         end
      end
   end

   assign out_valid = (state == DONE);

endmodule

// File: tb/tb_calc_unit.sv
// Self-checking bench for calc_unit (WIDTH=16):
// directed table, hand sequences, randomized ops vs model.
module tb_calc_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic        out_valid, out_ready;
   logic [3:0]  op, shamt, flags;
   logic [15:0] a, b, result;

   int checks = 0;
   int errors = 0;

   calc_unit #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .shamt     (shamt),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  o;
      logic [3:0]  sh;
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] r;
      logic [3:0]  f;
      int          lat;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // flags = {S,Z,C,V}; lat = cycles from accept to out_valid
   function automatic void model(
      input  logic [3:0]  o,
      input  logic [3:0]  sh,
      input  logic [15:0] x,
      input  logic [15:0] y,
      output logic [15:0] r,
      output logic [3:0]  f,
      output int          lat);
      int     ua, ub, sa, sb, t;
      longint p;
      logic   c, v;
      ua = int'(x);
      ub = int'(y);
      sa = int'($signed(x));
      sb = int'($signed(y));
      c = 1'b0;
      v = 1'b0;
      lat = 1;
      r = 16'h0;
      f = 4'h0;
      case (o)
         4'h0: begin
            t = ua + ub;
            r = t[15:0];
            c = (t > 65535);
            v = (sa + sb > 32767) || (sa + sb < -32768);
         end
         4'h1, 4'h5: begin
            t = ub - ua;
            r = t[15:0];
            c = (ub < ua);
            v = (sb - sa > 32767) || (sb - sa < -32768);
         end
         4'h2: r = x & y;
         4'h3: r = x | y;
         4'h4: r = x ^ y;
         4'h6: r = y;
         4'h7: begin
            p = longint'(ua) * longint'(ub);
            r = p[15:0];
            c = (p > 65535);
            v = c;
            lat = 17;
         end
         4'h8: begin
            r = y << sh;
            if (sh != 0) c = y[16 - int'(sh)];
         end
         4'h9: r = (y << sh) | (y >> (16 - int'(sh)));
         4'hA: begin
            r = y >> sh;
            if (sh != 0) c = y[int'(sh) - 1];
         end
         4'hB: begin
            t = sb >>> sh;
            r = t[15:0];
            if (sh != 0) c = y[int'(sh) - 1];
         end
         4'hC: begin
            if (ua == 0) begin
               r = 16'hFFFF;
               v = 1'b1;
            end else begin
               t = ub / ua;
               r = t[15:0];
               lat = 17;
            end
         end
         4'hD: begin
            if (ua == 0) begin
               r = y;
               v = 1'b1;
            end else begin
               t = ub % ua;
               r = t[15:0];
               lat = 17;
            end
         end
         default: return;
      endcase
      f = {r[15], r == 16'h0, c, v};
   endfunction

   task automatic run_op(input logic [3:0]  o,
                         input logic [3:0]  sh,
                         input logic [15:0] x,
                         input logic [15:0] y,
                         input logic [15:0] er,
                         input logic [3:0]  ef,
                         input int          elat,
                         input int          hold,
                         input string       nm);
      int   n;
      logic saw;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk({nm, " rdy"}, 32'(in_ready), 1);
      op = o;
      shamt = sh;
      a = x;
      b = y;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      op = 4'($urandom);
      shamt = 4'($urandom);
      a = 16'($urandom);
      b = 16'($urandom);
      n = 1;
      saw = 1'b0;
      while (!out_valid && n < 100) begin
         if (in_ready) saw = 1'b1;
         @(posedge clk); #1;
         n++;
      end
      chk({nm, " lat"}, 32'(n), 32'(elat));
      chk({nm, " res"}, 32'(result), 32'(er));
      chk({nm, " flg"}, 32'(flags), 32'(ef));
      if (elat > 1) chk({nm, " busy"}, 32'(saw), 0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk({nm, " hold"},
             {11'h0, out_valid, flags, result},
             {11'h0, 1'b1, ef, er});
      end
      chk({nm, " done nrdy"}, 32'(in_ready), 0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({nm, " consumed"}, 32'(out_valid), 0);
      chk({nm, " rdy after"}, 32'(in_ready), 1);
   endtask

   initial begin
      logic [3:0]  ro, rs, ef;
      logic [15:0] rx, ry, er;
      int          el;
      logic        saw;

      tbl[0]  = '{4'h0, 4'h0, 16'h7FFF, 16'h0001,
                  16'h8000, 4'b1001, 1};
      tbl[1]  = '{4'h1, 4'h0, 16'h0001, 16'h0000,
                  16'hFFFF, 4'b1010, 1};
      tbl[2]  = '{4'h5, 4'h0, 16'h0005, 16'h0005,
                  16'h0000, 4'b0100, 1};
      tbl[3]  = '{4'h7, 4'h0, 16'h0100, 16'h0100,
                  16'h0000, 4'b0111, 17};
      tbl[4]  = '{4'hC, 4'h0, 16'h0003, 16'h000A,
                  16'h0003, 4'b0000, 17};
      tbl[5]  = '{4'hD, 4'h0, 16'h0003, 16'h000A,
                  16'h0001, 4'b0000, 17};
      tbl[6]  = '{4'hC, 4'h0, 16'h0000, 16'h0005,
                  16'hFFFF, 4'b1001, 1};
      tbl[7]  = '{4'hB, 4'h1, 16'h0000, 16'h8001,
                  16'hC000, 4'b1010, 1};
      tbl[8]  = '{4'h9, 4'h4, 16'h0000, 16'h8001,
                  16'h0018, 4'b0000, 1};
      tbl[9]  = '{4'h8, 4'h0, 16'h0000, 16'h1234,
                  16'h1234, 4'b0000, 1};
      tbl[10] = '{4'hE, 4'h3, 16'hFFFF, 16'hFFFF,
                  16'h0000, 4'b0000, 1};
      tbl[11] = '{4'hD, 4'h0, 16'h0000, 16'h1234,
                  16'h1234, 4'b0001, 1};

      rst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      op = '0;
      shamt = '0;
      a = '0;
      b = '0;
      #1 rst = 1'b1;
      #2;
      chk("reset ov", 32'(out_valid), 0);
      chk("reset res", 32'(result), 0);
      chk("reset flg", 32'(flags), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("reset rdy", 32'(in_ready), 1);

      foreach (tbl[i])
         run_op(tbl[i].o, tbl[i].sh, tbl[i].x, tbl[i].y,
                tbl[i].r, tbl[i].f, tbl[i].lat, 0,
                $sformatf("vec%0d", i));

      run_op(4'h0, 4'h0, 16'h1234, 16'h4321,
             16'h5555, 4'b0000, 1, 5, "hold add");
      run_op(4'h7, 4'h0, 16'h0003, 16'h0005,
             16'h000F, 4'b0000, 17, 5, "hold mul");

      // reset in the middle of a multiply
      op = 4'h7;
      a = 16'hFFFF;
      b = 16'hFFFF;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("midrst ov", 32'(out_valid), 0);
      chk("midrst res", 32'(result), 0);
      chk("midrst flg", 32'(flags), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      saw = 1'b0;
      repeat (30) begin
         @(posedge clk); #1;
         if (out_valid) saw = 1'b1;
      end
      chk("midrst nores", 32'(saw), 0);
      chk("midrst rdy", 32'(in_ready), 1);

      for (int i = 0; i < 150; i++) begin
         ro = 4'($urandom_range(0, 15));
         rs = 4'($urandom);
         rx = ($urandom_range(0, 5) == 0) ? 16'h0
                                          : 16'($urandom);
         ry = 16'($urandom);
         model(ro, rs, rx, ry, er, ef, el);
         run_op(ro, rs, rx, ry, er, ef, el,
                $urandom_range(0, 2),
                $sformatf("rnd%0d op%h", i, ro));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
